multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control unit for the multi-cycle RISC-V core, replacing the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, waiting on a memory ready handshake. It drives datapath mux selects and write enables, traps illegal opcodes, and counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
- `MEM_WAIT_EN`, default 1: if 1, the FETCH, MEMREAD and MEMWRITE states wait for `mem_ready`; if 0, `mem_ready` is ignored and treated as 1.
- `EXT_OPS_EN`, default 1: if 1, JAL (1101111) and LUI (0110111) are legal; if 0, both trap.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Op` in 7: opcode field from the instruction register.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register and OldPC enable.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2: ALU B select; 00 = rs2, 01 = imm, 10 = 4.
- `ALUOp` out 2: to the ALU decoder; 00 = add, 01 = sub/branch, 10 = funct-decoded.
- `ImmSrc` out 3: immediate type.
- `illegal_op` out 1: sticky trap flag.
- `retired` out 1: one-cycle pulse when an instruction completes.
- `retired_count` out CNT_W: count of retired instructions.
- `state_o` out 4: current state, for debug.

## Operation
- State register resets to FETCH. `illegal_op` resets to 0 and `retired_count` resets to 0. All outputs are Moore outputs; every one not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when `mem_ready`=1.
  - Transition to DECODE when `mem_ready`=1; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by `Op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL, if EXT_OPS_EN
  - 0110111 → LUI, if EXT_OPS_EN
  - any other opcode → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if `Op`=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Transition to MEMWB when ready.
- MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite is held until ready, then the FSM goes to FETCH.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1, then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, then ALUWB.
- TRAP: all enables are 0 and `illegal_op`=1. The FSM stays in TRAP until reset.
- `PCWrite` = PCUpdate | (Branch & Zero).
- `ImmSrc` is combinational from `Op`, not from state:
  - S-type = 001
  - B-type = 010
  - J-type = 011
  - U-type = 100
  - anything else = 000
- A state transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ:
  - pulses `retired` for that one cycle;
  - increments `retired_count`, which wraps modulo 2^CNT_W.

## Timing
- Instruction latency with zero wait states:
  - lw 5 cycles; sw 4; R/I-type 4; beq 3.
  - jal 4; lui 4.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs hold stable while waiting.
- Asserting `rst_n` mid-instruction immediately forces state to FETCH and clears all write enables, with no clock edge required. Counter and trap flag clear at the same time.
- `retired` is high in the cycle after the final state, aligned with the first FETCH cycle.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - 4-bit state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, LUI=11, TRAP=15;
  - opcode constants;
  - ImmSrc, ResultSrc and ALUSrc encodings.
- One sub-module, `imm_src_decoder`, is the combinational Op→ImmSrc map, reusable by the single-cycle core.

## Test plan
- **Reset:** drop `rst_n` while in MEMREAD → state_o=0 and all enables 0 asynchronously. On release, FETCH with IRWrite=1 once `mem_ready`=1.
- **Zero-wait sequence:** `mem_ready`=1 with lw, sw, add, addi, beq → retirements at 5/4/4/4/3 cycles and `retired_count`=5.
- **Memory wait:** `mem_ready` low for 3 cycles in FETCH and 2 in MEMWRITE → sw takes 9 cycles, MemWrite is held 3 cycles, and exactly one PCWrite occurs.
- **Branch:** beq with Zero=1 → PCWrite=1 in BEQ. With Zero=0 → PCWrite=0 and the FSM still returns to FETCH.
- **Extended ops and trap:**
  - EXT_OPS_EN=1: jal → PCWrite in JAL then RegWrite in ALUWB; lui → ALUSrcA=11 and ImmSrc=100.
  - EXT_OPS_EN=0: jal → TRAP, `illegal_op`=1, and no further writes.
- **Counter wrap:** CNT_W=4, 17 addi instructions → `retired_count`=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states, opcodes,
// datapath mux selects and the decode-stage dispatch helper.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Where DECODE dispatches; extension opcodes trap when the extension is disabled.
  function automatic state_t decodeTarget(input logic [6:0] op, input bit extOps);
    case (op)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_RTYPE:          return EXECR;
      OP_ITYPE:          return EXECI;
      OP_BRANCH:         return BEQ;
      OP_JAL:            return extOps ? JAL : TRAP;
      OP_LUI:            return extOps ? LUI : TRAP;
      default:           return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller (master) and the shared-memory datapath (slave).
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  // Handshake: an access in FETCH, MEMREAD or MEMWRITE completes in the cycle
  // mem_ready is high; until then every control output holds its value.
  logic [6:0] Op;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );

endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-type map; purely combinational so the single-cycle core can share it.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
    input  logic [6:0] Op,
    output logic [2:0] ImmSrc
);

    always_comb begin
        ImmSrc = IMM_I;
        case (Op)
            OP_STORE:          ImmSrc = IMM_S;
            OP_BRANCH:         ImmSrc = IMM_B;
            OP_JAL:            ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
            default:           ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing each instruction through fetch/decode/execute/memory/writeback,
// with a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_OPS_EN  = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_controller_if.master   bus,
    output logic                      illegal_op,
    output logic                      retired,
    output logic [CNT_W-1:0]          retired_count,
    output logic [3:0]                state_o
);

    state_t state;
    state_t decodeNext;
    logic   memReady;
    logic   retireNow;
    logic   pcUpdate;
    logic   branch;
    logic   irWrite;
    logic   memWrite;
    logic   regWrite;

    assign memReady   = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign decodeNext = decodeTarget(bus.Op, EXT_OPS_EN);
    assign retireNow  = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                        ((state == MEMWRITE) && memReady);
    assign state_o    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            illegal_op    <= 1'b0;
            retired       <= 1'b0;
            retired_count <= '0;
        end else begin
            retired <= retireNow;
            if (retireNow) retired_count <= retired_count + CNT_W'(1);
            case (state)
                FETCH:    if (memReady) state <= DECODE;
                DECODE: begin
                    state <= decodeNext;
                    if (decodeNext == TRAP) illegal_op <= 1'b1;
                end
                MEMADR:   state <= (bus.Op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (memReady) state <= MEMWB;
                MEMWRITE: if (memReady) state <= FETCH;
                MEMWB, ALUWB, BEQ:        state <= FETCH;
                EXECR, EXECI, JAL, LUI:   state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Selects and enables are decoded from the state register alone, except the
    // fetch enables, which wait on the memory handshake.
    always_comb begin
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ALUOp     = ALUOP_ADD;
        pcUpdate      = 1'b0;
        branch        = 1'b0;
        irWrite       = 1'b0;
        memWrite      = 1'b0;
        regWrite      = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                irWrite       = memReady;
                pcUpdate      = memReady;
            end
            DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                memWrite   = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = RES_DATA;
                regWrite      = 1'b1;
            end
            EXECR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: regWrite = 1'b1;
            BEQ: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUOp   = ALUOP_SUB;
                branch      = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pcUpdate    = 1'b1;
            end
            LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    // Write enables drop the moment reset asserts, even though FETCH would otherwise fetch.
    assign bus.PCWrite  = rst_n & (pcUpdate | (branch & bus.Zero));
    assign bus.IRWrite  = rst_n & irWrite;
    assign bus.MemWrite = rst_n & memWrite;
    assign bus.RegWrite = rst_n & regWrite;

    imm_src_decoder uImmSrc (
        .Op     (bus.Op),
        .ImmSrc (bus.ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model predicting per-cycle outputs,
// plus a second instance with the extensions off and a 4-bit counter.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BEQI = 7'b1100011;
  localparam logic [6:0] JALI = 7'b1101111;
  localparam logic [6:0] LUII = 7'b0110111;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, adr, irw, mw, rw;
    logic [1:0]  res, sa, sb, aop;
    logic [2:0]  imm;
    logic        ill, ret;
    logic [31:0] cnt;
  } obs_t;

  logic clk;
  logic rst_n;
  logic rst_b;

  multicycle_controller_if bus ();
  multicycle_controller_if bus_b ();

  logic        ill, ret;
  logic [31:0] cnt;
  logic [3:0]  st;
  logic        ill_b, ret_b;
  logic [3:0]  cnt_b;
  logic [3:0]  st_b;

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .illegal_op    (ill),
    .retired       (ret),
    .retired_count (cnt),
    .state_o       (st)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b1), .EXT_OPS_EN(1'b0), .CNT_W(4)) dut_b (
    .clk           (clk),
    .rst_n         (rst_b),
    .bus           (bus_b),
    .illegal_op    (ill_b),
    .retired       (ret_b),
    .retired_count (cnt_b),
    .state_o       (st_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  int   cyc = 0;
  int   base = 0;
  bit   track = 0;
  int   ret_cyc[$];
  bit   win = 0;
  int   win_pcw = 0;
  int   win_mw = 0;
  int   win_cycles = 0;

  // model state: retirement pending for the next cycle, and the running count
  bit   pend = 0;
  int   mcnt = 0;

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    if (op == SW) return 3'b001;
    if (op == BEQI) return 3'b010;
    if (op == JALI) return 3'b011;
    if (op == LUII || op == 7'b0010111) return 3'b100;
    return 3'b000;
  endfunction

  function automatic obs_t expect_cycle(input int s, input bit rdy, input bit z,
                                        input logic [6:0] op, input bit r, input int c);
    obs_t e;
    e = '0;
    e.st  = 4'(s);
    e.imm = exp_imm(op);
    e.ret = r;
    e.cnt = 32'(c);
    case (s)
      0:  begin e.sb = 2'b10; e.res = 2'b10; e.irw = rdy; e.pcw = rdy; end
      1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      3:  e.adr = 1'b1;
      4:  begin e.res = 2'b01; e.rw = 1'b1; end
      5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      6:  begin e.sa = 2'b10; e.aop = 2'b10; end
      7:  e.rw = 1'b1;
      8:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      10: begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
      11: begin e.sa = 2'b11; e.sb = 2'b01; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // driver: one instruction, fw/mw stall cycles in FETCH and in the memory state.
  // Called just after a rising edge; returns just after the edge that ends it.
  task automatic run_instr(input logic [6:0] op, input bit z, input int fw, input int mw);
    int sq[$];
    bit rq[$];
    repeat (fw) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'b1);
    case (op)
      LW: begin
        sq.push_back(2); rq.push_back(1'b1);
        repeat (mw) begin sq.push_back(3); rq.push_back(1'b0); end
        sq.push_back(3); rq.push_back(1'b1);
        sq.push_back(4); rq.push_back(1'b1);
      end
      SW: begin
        sq.push_back(2); rq.push_back(1'b1);
        repeat (mw) begin sq.push_back(5); rq.push_back(1'b0); end
        sq.push_back(5); rq.push_back(1'b1);
      end
      ADD:  begin sq.push_back(6);  rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b1); end
      ADDI: begin sq.push_back(8);  rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b1); end
      BEQI: begin sq.push_back(10); rq.push_back(1'b1); end
      JALI: begin sq.push_back(9);  rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b1); end
      default: begin sq.push_back(11); rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b1); end
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      bus.Op = op;
      bus.Zero = z;
      bus.mem_ready = rq[i];
      exp_q.push_back(expect_cycle(sq[i], rq[i], z, op, (i == 0) && pend, mcnt));
      pend = 1'b0;
      @(posedge clk);
      #1;
    end
    pend = 1'b1;
    mcnt++;
  endtask

  // one stalled FETCH cycle, showing any pending retirement
  task automatic run_idle();
    bus.Op = 7'b0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    exp_q.push_back(expect_cycle(0, 1'b0, 1'b0, 7'b0, pend, mcnt));
    pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every predicted cycle at the falling edge
  initial begin
    obs_t g, w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        g = {st, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, ill, ret, cnt};
        checks++;
        if (g !== w) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got %h want %h", cyc, g, w);
        end
      end
      if (track && ret) ret_cyc.push_back(cyc - base);
      if (win) begin
        win_cycles++;
        if (bus.PCWrite) win_pcw++;
        if (bus.MemWrite) win_mw++;
      end
      cyc++;
    end
  end

  initial begin
    rst_n = 1'b0;
    rst_b = 1'b0;
    bus.Op = 7'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    bus_b.Op = 7'b0; bus_b.Zero = 1'b0; bus_b.mem_ready = 1'b1;
    #12;
    check("reset_state", 64'(st), 64'd0);
    check("reset_enables", 64'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 64'd0);
    check("reset_flags", 64'({ill, ret}), 64'd0);
    check("reset_count", 64'(cnt), 64'd0);

    // zero-wait sequence
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc;
    track = 1'b1;
    run_instr(LW, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 0, 0);
    run_instr(ADD, 1'b0, 0, 0);
    run_instr(ADDI, 1'b0, 0, 0);
    run_instr(BEQI, 1'b1, 0, 0);
    run_idle();
    track = 1'b0;
    check("retire_pulses", 64'(ret_cyc.size()), 64'd5);
    if (ret_cyc.size() == 5) begin
      check("retire_lw", 64'(ret_cyc[0]), 64'd5);
      check("retire_sw", 64'(ret_cyc[1]), 64'd9);
      check("retire_add", 64'(ret_cyc[2]), 64'd13);
      check("retire_addi", 64'(ret_cyc[3]), 64'd17);
      check("retire_beq", 64'(ret_cyc[4]), 64'd20);
    end
    check("count_after_5", 64'(cnt), 64'd5);

    // branch not taken, stalled store, extended ops
    run_instr(BEQI, 1'b0, 0, 0);
    win = 1'b1;
    run_instr(SW, 1'b0, 3, 2);
    win = 1'b0;
    check("sw_wait_cycles", 64'(win_cycles), 64'd9);
    check("sw_wait_memwrite", 64'(win_mw), 64'd3);
    check("sw_wait_pcwrite", 64'(win_pcw), 64'd1);
    run_instr(JALI, 1'b0, 0, 0);
    run_instr(LUII, 1'b1, 1, 0);
    run_instr(LW, 1'b0, 2, 3);
    run_idle();
    check("count_after_10", 64'(cnt), 64'd10);

    // asynchronous reset while stalled in MEMREAD
    bus.Op = LW; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memread_reached", 64'(st), 64'd3);
    #1;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("async_state", 64'(st), 64'd0);
    check("async_enables", 64'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 64'd0);
    check("async_count", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend = 1'b0;
    mcnt = 0;
    #1;
    check("release_irwrite", 64'(bus.IRWrite), 64'd1);
    run_instr(ADDI, 1'b0, 0, 0);
    run_idle();
    check("count_after_reset", 64'(cnt), 64'd1);

    // second instance: counter wrap, then trap on jal with extensions off
    rst_n = 1'b0;
    rst_b = 1'b1;
    bus_b.Op = ADDI;
    bus_b.mem_ready = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    check("wrap_16", 64'({st_b, ret_b, cnt_b}), 64'({4'd0, 1'b1, 4'd0}));
    repeat (4) @(posedge clk);
    #1;
    check("wrap_17", 64'({st_b, ret_b, cnt_b}), 64'({4'd0, 1'b1, 4'd1}));
    bus_b.Op = JALI;
    repeat (2) @(posedge clk);
    #1;
    check("trap_state", 64'(st_b), 64'd15);
    check("trap_flag", 64'(ill_b), 64'd1);
    for (int i = 0; i < 6; i++) begin
      bus_b.mem_ready = 1'($urandom_range(0, 1));
      bus_b.Zero = 1'b1;
      bus_b.Op = (i < 3) ? SW : ADDI;
      @(posedge clk);
      #1;
      check("trap_hold", 64'({st_b, ill_b, bus_b.PCWrite, bus_b.IRWrite, bus_b.MemWrite,
                              bus_b.RegWrite, cnt_b}),
            64'({4'd15, 1'b1, 4'b0000, 4'd1}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
